// File: rtl/chunker_pkg.sv
// Shared constants and helpers for the chunker width converter.
package chunker_pkg;

   localparam int CHUNKER_L_DEFAULT = 8;
   localparam int CHUNKER_M_DEFAULT = 2;

   // A single-chunk word still needs a one-bit counter.
   function automatic int chunk_cnt_w(input int nr);
      return (nr > 1) ? $clog2(nr) : 1;
   endfunction

endpackage

// File: rtl/chunker.sv
// Parallel-to-serial converter: an L-bit word leaves as L/M chunks, MSB chunk first.
// Define CHUNKER_LAST_EN to add a 'last' output that marks the final chunk.
module chunker
   import chunker_pkg::*;
#(
   parameter int L = CHUNKER_L_DEFAULT,
   parameter int M = CHUNKER_M_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [L-1:0] data_in,
   input  logic         strobe,
   output logic [M-1:0] q,
   output logic         valid
`ifdef CHUNKER_LAST_EN
   ,
   output logic         last
`endif
);

   localparam int NR = L / M;
   localparam int CW = chunk_cnt_w(NR);

   generate
      if ((L % M) != 0) begin : g_bad_params
         $fatal(1, "chunker: L must be an exact multiple of M");
      end
   endgenerate

   logic [L-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  q_q, q_d;
   logic          valid_q, valid_d;
`ifdef CHUNKER_LAST_EN
   logic          last_q, last_d;
`endif

   // cnt_q counts chunks still waiting in shift_q; a strobe always wins and restarts.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      q_d     = '0;
      valid_d = 1'b0;
`ifdef CHUNKER_LAST_EN
      last_d  = 1'b0;
`endif
      if (strobe) begin
         q_d     = data_in[L-1 -: M];
         shift_d = data_in << M;
         cnt_d   = CW'(NR - 1);
         valid_d = 1'b1;
`ifdef CHUNKER_LAST_EN
         last_d  = (NR == 1);
`endif
      end else if (valid_q && (cnt_q != '0)) begin
         q_d     = shift_q[L-1 -: M];
         shift_d = shift_q << M;
         cnt_d   = cnt_q - CW'(1);
         valid_d = 1'b1;
`ifdef CHUNKER_LAST_EN
         last_d  = (cnt_q == CW'(1));
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
`ifdef CHUNKER_LAST_EN
         last_q  <= 1'b0;
`endif
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         valid_q <= valid_d;
`ifdef CHUNKER_LAST_EN
         last_q  <= last_d;
`endif
      end
   end

   assign q     = q_q;
   assign valid = valid_q;
`ifdef CHUNKER_LAST_EN
   assign last  = last_q;
`endif

endmodule

// File: tb/tb_chunker.sv
// Randomized scoreboard bench for chunker, run side by side at M = 2, 8, 4 and 1 with L = 8.
`timescale 1ns/1ps
module tb_chunker;

   localparam int L  = 8;
   localparam int NI = 4;

   typedef struct packed {
      logic [NI-1:0]      v;
      logic [NI-1:0]      l;
      logic [NI-1:0][7:0] c;
   } cyc_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       strobe;
   logic [7:0] data_in;

   logic [1:0] q2;
   logic [7:0] q8;
   logic [3:0] q4;
   logic [0:0] q1;
   logic       v2, v8, v4, v1;
   wire  [NI-1:0] vv = {v1, v4, v8, v2};
`ifdef CHUNKER_LAST_EN
   logic       l2, l8, l4, l1;
   wire  [NI-1:0] ll = {l1, l4, l8, l2};
`endif

   cyc_t       sb [$];
   logic [7:0] seen2 [$];
   logic [7:0] seen8 [$];
   logic [7:0] seen4 [$];
   logic [7:0] seen1 [$];
   int         checks;
   int         failures;

   always #5 clk = ~clk;

   chunker #(.L(L), .M(2)) u_dut (
      .clk(clk), .reset(reset), .data_in(data_in), .strobe(strobe), .q(q2), .valid(v2)
`ifdef CHUNKER_LAST_EN
      , .last(l2)
`endif
   );
   chunker #(.L(L), .M(8)) u_m8 (
      .clk(clk), .reset(reset), .data_in(data_in), .strobe(strobe), .q(q8), .valid(v8)
`ifdef CHUNKER_LAST_EN
      , .last(l8)
`endif
   );
   chunker #(.L(L), .M(4)) u_m4 (
      .clk(clk), .reset(reset), .data_in(data_in), .strobe(strobe), .q(q4), .valid(v4)
`ifdef CHUNKER_LAST_EN
      , .last(l4)
`endif
   );
   chunker #(.L(L), .M(1)) u_m1 (
      .clk(clk), .reset(reset), .data_in(data_in), .strobe(strobe), .q(q1), .valid(v1)
`ifdef CHUNKER_LAST_EN
      , .last(l1)
`endif
   );

   function automatic int m_of(input int i);
      case (i)
         0:       return 2;
         1:       return 8;
         2:       return 4;
         default: return 1;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: each accepted strobe replaces the whole pending schedule with the new word's chunks.
   always @(posedge clk) begin : model
      cyc_t e;
      int   m;
      int   nr;
      if (reset && strobe) begin
         sb.delete();
         for (int j = 0; j < 8; j++) begin
            e = '0;
            for (int i = 0; i < NI; i++) begin
               m  = m_of(i);
               nr = L / m;
               if (j < nr) begin
                  e.v[i] = 1'b1;
                  e.c[i] = 8'((int'(data_in) >> ((nr - 1 - j) * m)) & ((1 << m) - 1));
                  e.l[i] = (j == nr - 1);
               end
            end
            if (e.v != '0) sb.push_back(e);
         end
      end
   end

   always @(negedge reset) sb.delete();

   always @(negedge clk) begin : monitor
      cyc_t               e;
      logic [NI-1:0][7:0] act;
      if (sb.size() != 0) e = sb.pop_front();
      else                e = '0;
      act[0] = {6'd0, q2};
      act[1] = q8;
      act[2] = {4'd0, q4};
      act[3] = {7'd0, q1};
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("valid_m%0d", m_of(i)), {7'd0, vv[i]}, {7'd0, e.v[i]});
         checkOutput($sformatf("q_m%0d", m_of(i)), act[i], e.c[i]);
`ifdef CHUNKER_LAST_EN
         checkOutput($sformatf("last_m%0d", m_of(i)), {7'd0, ll[i]}, {7'd0, e.l[i]});
`endif
      end
      if (v2) seen2.push_back(act[0]);
      if (v8) seen8.push_back(act[1]);
      if (v4) seen4.push_back(act[2]);
      if (v1) seen1.push_back(act[3]);
   end

   task automatic applyStimulus(input logic [7:0] d, input int hold);
      @(negedge clk);
      #1;
      strobe  = 1'b1;
      data_in = d;
      for (int h = 1; h < hold; h++) begin
         @(negedge clk);
         #1;
         data_in = 8'($urandom);
      end
      @(negedge clk);
      #1;
      strobe  = 1'b0;
      data_in = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clearSeen();
      seen2.delete();
      seen8.delete();
      seen4.delete();
      seen1.delete();
   endtask

   task automatic checkSeq(input string tag, input logic [7:0] got [$], input logic [7:0] exp [$]);
      checkOutput({tag, "_count"}, 8'(got.size()), 8'(exp.size()));
      for (int k = 0; k < exp.size(); k++)
         if (k < got.size()) checkOutput($sformatf("%s_chunk%0d", tag, k), got[k], exp[k]);
   endtask

   task automatic checkBasic(input string tag);
      checkSeq({tag, "_m2"}, seen2, '{8'h1, 8'h2, 8'h2, 8'h1});
      checkSeq({tag, "_m8"}, seen8, '{8'h69});
      checkSeq({tag, "_m4"}, seen4, '{8'h6, 8'h9});
      checkSeq({tag, "_m1"}, seen1, '{8'h0, 8'h1, 8'h1, 8'h0, 8'h1, 8'h0, 8'h0, 8'h1});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      strobe   = 1'b0;
      data_in  = 8'h00;
      #1 reset = 1'b0;

      applyStimulus(8'hFF, 1);
      applyStimulus(8'h69, 2);
      checkOutput("reset_valid", {4'd0, vv}, 8'h00);
      @(negedge clk);
      #1 reset = 1'b1;
      idle(3);

      clearSeen();
      applyStimulus(8'h69, 1);
      idle(9);
      checkBasic("basic1");

      clearSeen();
      applyStimulus(8'h69, 1);
      idle(9);
      checkBasic("basic2");

      clearSeen();
      applyStimulus(8'hA5, 1);
      applyStimulus(8'h3C, 1);
      idle(8);
      checkSeq("abort_m2", seen2, '{8'h2, 8'h2, 8'h0, 8'h3, 8'h3, 8'h0});

      clearSeen();
      applyStimulus(8'hC3, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("async_valid", {4'd0, vv}, 8'h00);
      checkOutput("async_q_m2", {6'd0, q2}, 8'h00);
      checkOutput("async_q_m8", q8, 8'h00);
      @(negedge clk);
      #1 reset = 1'b1;
      idle(10);
      checkSeq("async_m2", seen2, '{8'h3});

      for (int it = 0; it < 60; it++) begin
         applyStimulus(8'($urandom), $urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) begin
            #2 reset = 1'b0;
            #3 reset = 1'b1;
         end
         idle($urandom_range(0, 9));
      end
      idle(12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chunker.md
Name: chunker

Overview:
- Parallel-to-serial width converter.
- On a one-cycle strobe it captures an L-bit word and emits it as L/M consecutive M-bit chunks, most-significant chunk first, one chunk per clock with a valid qualifier.
- Sits between a wide producer (e.g. a hash/extractor word output) and a narrow streaming consumer.

Parameters:
- L, 8, input word width in bits; must be an exact multiple of M.
- M, 2, chunk (output) width in bits; 1 <= M <= L.
- NR (localparam), L/M, number of chunks per word.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low; asserted (0) clears all state immediately.
- data_in, input, L, parallel word; sampled only on a clk edge where strobe=1.
- strobe, input, 1, load request; one-cycle pulse typical.
- q, output, M, current chunk.
- valid, output, 1, q holds a valid chunk this cycle.

Behaviour:
- Reset (reset=0, async): shift register cleared, chunk counter=0, busy=0, valid=0, q=0. All outputs are registered.
- Idle: valid=0, q=0.
- Load: at a rising edge with strobe=1, capture data_in into an L-bit shift register and start emission.
- Emission:
  - Chunk k (k=0..NR-1) = data_in[(NR-1-k)*M +: M].
  - Chunk 0 is presented with valid=1 immediately after the load edge, i.e. it is visible at the next rising edge.
  - Chunks 1..NR-1 follow on consecutive cycles.
  - valid is high for exactly NR consecutive cycles.
- End: after chunk NR-1, valid=0 and q=0 on the next cycle; return to idle.
- Latency: strobe sampled at edge N -> chunk 0 valid at edge N+1 (registered), last chunk at edge N+NR.
- Strobe while busy: abort the current word, capture the new data_in, restart at chunk 0 on the next cycle. No merging and no queueing.
- Strobe held high for several cycles: every sampled edge reloads, so only the final capture is emitted completely.
- data_in changes after the load edge have no effect on the word being emitted.
- Reset mid-emission: output stops at once (valid=0, q=0); no resume after reset release.
- NR=1 (M=L): a single cycle with valid=1 and q=data_in.
- Counter width: max(1, $clog2(NR)).
- Elaboration check: L % M == 0, otherwise fatal.

Optional Feature:
- Macro CHUNKER_LAST_EN.
- Defined: adds output port last (1 bit), high together with valid only on chunk NR-1. It is 0 under reset and while idle, and an aborted word never asserts last.
- Undefined: the port does not exist; behaviour is otherwise identical.

Decomposition:
- chunker_pkg holds:
  - default constants CHUNKER_L_DEFAULT=8 and CHUNKER_M_DEFAULT=2;
  - a function chunk_cnt_w(nr) returning the counter width.
- No sub-module: the datapath is a single shift register plus down-counter and is kept inline.

Test Plan:
- Reset: hold reset=0 with strobe pulses -> valid=0, q=0 throughout; release -> still idle.
- Basic (L=8, M=2): data_in=0b01101001, one-cycle strobe -> valid for 4 cycles, q=01, 10, 10, 01, then valid=0, q=0.
- Second strobe on the same data ten cycles later -> identical sequence 01, 10, 10, 01; the scoreboard counter resets between words.
- Abort: strobe 0xA5 with L=8, M=2, restrobe 0x3C after 2 chunks:
  - q=10, 10, then 00, 11, 11, 00;
  - valid stays continuously high for 6 cycles.
- Async reset mid-word: assert reset=0 between edges after chunk 1 -> valid and q drop to 0 without waiting for a clock edge; no further chunks after release.
- Parameter sweep: L=8 with M=8, 4 and 1 on data 0x69 -> 1, 2 and 8 chunks respectively, MSB first. With CHUNKER_LAST_EN, last is high only on the final chunk.
